// File: rtl/vx_gpr_pkg.sv
// rtl/vx_gpr_pkg.sv - shared types, sizes and bank addressing for the GPR operand collector
package vx_gpr_pkg;

   localparam int GPR_NUM_WARPS = 4;
   localparam int GPR_NUM_REGS  = 32;
   localparam int WID_W         = $clog2(GPR_NUM_WARPS);
   localparam int REG_W         = $clog2(GPR_NUM_REGS);
   localparam int RF_ADDRW      = $clog2(GPR_NUM_WARPS * GPR_NUM_REGS);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      RSP
   } gpr_state_e;

   typedef enum logic [1:0] {
      RS1,
      RS2,
      RS3
   } op_sel_e;

   function automatic logic [RF_ADDRW-1:0] rf_addr(input logic [WID_W-1:0] wid,
                                                   input logic [REG_W-1:0] rid);
      return RF_ADDRW'(wid) * RF_ADDRW'(GPR_NUM_REGS) + RF_ADDRW'(rid);
   endfunction

endpackage

// File: rtl/vx_gpr_bank.sv
// rtl/vx_gpr_bank.sv - 1R1W synchronous register bank with per-lane write mask and write-first bypass
module vx_gpr_bank #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int LANES = 4,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [LANES*XLEN-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [LANES-1:0]      wr_mask,
   input  logic [LANES*XLEN-1:0] wr_data
);

   logic [LANES*XLEN-1:0] mem [DEPTH];
   logic [LANES*XLEN-1:0] rd_merged;

   // Same-address write in the read cycle wins for its enabled lanes only.
   always_comb begin
      rd_merged = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         for (int l = 0; l < LANES; l++) begin
            if (wr_mask[l]) begin
               rd_merged[l*XLEN +: XLEN] = wr_data[l*XLEN +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= rd_merged;
      end
      if (wr_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (wr_mask[l]) begin
               mem[wr_addr][l*XLEN +: XLEN] <= wr_data[l*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/vx_gpr_collector.sv
// rtl/vx_gpr_collector.sv - operand collector: sequences per-warp GPR reads and presents rs1/rs2/rs3
module vx_gpr_collector
   import vx_gpr_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int NUM_WARPS   = GPR_NUM_WARPS,
   parameter int NUM_REGS    = GPR_NUM_REGS
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [$clog2(NUM_WARPS)-1:0]  req_wid,
   input  logic [$clog2(NUM_REGS)-1:0]   req_rs1,
   input  logic [$clog2(NUM_REGS)-1:0]   req_rs2,
   input  logic [$clog2(NUM_REGS)-1:0]   req_rs3,
   input  logic                          req_use_rs3,
   input  logic                          wb_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]  wb_wid,
   input  logic [$clog2(NUM_REGS)-1:0]   wb_rd,
   input  logic [NUM_THREADS-1:0]        wb_tmask,
   input  logic [NUM_THREADS*XLEN-1:0]   wb_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [$clog2(NUM_WARPS)-1:0]  rsp_wid,
   output logic [NUM_THREADS*XLEN-1:0]   rsp_rs1_data,
   output logic [NUM_THREADS*XLEN-1:0]   rsp_rs2_data,
   output logic [NUM_THREADS*XLEN-1:0]   rsp_rs3_data
);

   localparam int DW = NUM_THREADS * XLEN;

   gpr_state_e            state;
   op_sel_e               cap_sel;
   op_sel_e               sel;
   logic [2:0]            pend;
   logic [2:0]            need_req;
   logic [2:0]            src_mask;
   logic [2:0]            sel_mask;
   logic [REG_W-1:0]      rs1_q, rs2_q, rs3_q;
   logic [REG_W-1:0]      sel_idx;
   logic [WID_W-1:0]      sel_wid;
   logic                  accept;
   logic                  rd_en;
   logic                  wr_en;
   logic [RF_ADDRW-1:0]   rd_addr;
   logic [RF_ADDRW-1:0]   wr_addr;
   logic [DW-1:0]         rd_data;

   assign accept   = (state == IDLE) && req_valid && req_ready;
   assign need_req = {req_use_rs3 && (req_rs3 != '0), req_rs2 != '0, req_rs1 != '0};

   // The first read issues in the accept cycle straight from the request, which
   // is what makes a k-read collection finish k+1 cycles after acceptance.
   always_comb begin
      src_mask = (state == IDLE) ? need_req : pend;
      sel_wid  = (state == IDLE) ? req_wid : rsp_wid;
      sel      = RS1;
      sel_mask = 3'b001;
      if (src_mask[0]) begin
         sel      = RS1;
         sel_mask = 3'b001;
      end else if (src_mask[1]) begin
         sel      = RS2;
         sel_mask = 3'b010;
      end else if (src_mask[2]) begin
         sel      = RS3;
         sel_mask = 3'b100;
      end
      sel_idx = '0;
      case (sel)
         RS1:     sel_idx = (state == IDLE) ? req_rs1 : rs1_q;
         RS2:     sel_idx = (state == IDLE) ? req_rs2 : rs2_q;
         RS3:     sel_idx = (state == IDLE) ? req_rs3 : rs3_q;
         default: sel_idx = '0;
      endcase
   end

   assign rd_en   = (accept && (need_req != 3'b000)) || (state == READ);
   assign rd_addr = rf_addr(sel_wid, sel_idx);
   assign wr_en   = wb_valid && (wb_rd != '0);
   assign wr_addr = rf_addr(wb_wid, wb_rd);

   vx_gpr_bank #(
      .DEPTH (NUM_WARPS * NUM_REGS),
      .AW    (RF_ADDRW),
      .LANES (NUM_THREADS),
      .XLEN  (XLEN)
   ) u_bank (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_mask (wb_tmask),
      .wr_data (wb_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_wid      <= '0;
         rsp_rs1_data <= '0;
         rsp_rs2_data <= '0;
         rsp_rs3_data <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rs3_q        <= '0;
         pend         <= 3'b000;
         cap_sel      <= RS1;
      end else begin
         if ((state == READ) || (state == DRAIN)) begin
            case (cap_sel)
               RS1:     rsp_rs1_data <= rd_data;
               RS2:     rsp_rs2_data <= rd_data;
               RS3:     rsp_rs3_data <= rd_data;
               default: ;
            endcase
         end
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready    <= 1'b0;
                  rsp_wid      <= req_wid;
                  rs1_q        <= req_rs1;
                  rs2_q        <= req_rs2;
                  rs3_q        <= req_rs3;
                  rsp_rs1_data <= '0;
                  rsp_rs2_data <= '0;
                  rsp_rs3_data <= '0;
                  pend         <= need_req & ~sel_mask;
                  cap_sel      <= sel;
                  if (need_req == 3'b000) begin
                     state     <= RSP;
                     rsp_valid <= 1'b1;
                  end else if ((need_req & ~sel_mask) == 3'b000) begin
                     state <= DRAIN;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               cap_sel <= sel;
               pend    <= pend & ~sel_mask;
               if ((pend & ~sel_mask) == 3'b000) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state     <= RSP;
               rsp_valid <= 1'b1;
            end
            RSP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/vx_gpr_collector.md
Name: vx_gpr_collector

Overview:
- Operand-collection stage between the issue scoreboard and the dispatch stage.
- Accepts one instruction's register-read request: warp id and rs1/rs2/rs3 indices.
- Reads per-warp GPRs from an internal 1-read/1-write register bank, one operand per cycle, and absorbs writeback traffic.
- Presents assembled per-thread rs1/rs2/rs3 data with a valid/ready handshake. The rsp_* data ports drive the master side of the GPR response interface.

Parameters:
- NUM_THREADS, 4, threads per warp (data lanes)
- XLEN, 32, bits per lane
- NUM_WARPS, 4, warps sharing the bank
- NUM_REGS, 32, architectural registers per warp; register 0 is hardwired zero

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request valid
- req_ready  out  1  collector can accept a request
- req_wid  in  log2(NUM_WARPS)  warp id
- req_rs1 / req_rs2 / req_rs3  in  log2(NUM_REGS) each  source indices
- req_use_rs3  in  1  rs3 needed (FMA-class instruction)
- wb_valid  in  1  writeback valid (always accepted, no ready)
- wb_wid  in  log2(NUM_WARPS)  writeback warp
- wb_rd  in  log2(NUM_REGS)  destination register
- wb_tmask  in  NUM_THREADS  per-lane write enable
- wb_data  in  NUM_THREADS*XLEN  writeback data
- rsp_valid  out  1  operands ready
- rsp_ready  in  1  downstream accepts
- rsp_wid  out  log2(NUM_WARPS)  warp of response
- rsp_rs1_data / rsp_rs2_data / rsp_rs3_data  out  NUM_THREADS*XLEN each  collected operands

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; req_ready=0 while reset_n low, 1 in IDLE after reset.
  - rsp_valid=0; rsp_wid=0; all rsp data=0.
  - Bank contents are not reset.
- Reset mid-operation aborts the collection; no response is produced.
- Bank: NUM_WARPS*NUM_REGS entries of NUM_THREADS*XLEN, address = wid*NUM_REGS+reg.
  - Synchronous read: address in cycle N, data in cycle N+1.
  - Write commits at the clock edge, per lane under wb_tmask.
- Write-first bypass: a read and a write to the same address in the same cycle returns wb_data for masked lanes and old data for the other lanes.
- Writes with wb_rd=0 are dropped.
- States:
  - IDLE: req_ready=1. On req_valid, latch wid, indices and use_rs3; build the read list in order rs1, rs2, rs3. An operand is skipped (captured as all-zero) when its index=0, or for rs3 when use_rs3=0. Empty list -> RSP; otherwise -> READ.
  - READ: issue one bank read per cycle in list order. Data is captured the cycle after each issue. After the last issue -> DRAIN.
  - DRAIN: capture the final read data -> RSP.
  - RSP: rsp_valid=1. Data and wid stay stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE, and rsp_valid drops next cycle.
- req_ready=0 in every state except IDLE; no back-to-back overlap.
- Latency with k required reads (0..3), measured from the acceptance edge:
  - k=0: rsp_valid on the next cycle.
  - k>0: rsp_valid at cycle k+1.
- Hazards: the upstream scoreboard guarantees no pending writeback to a source register. A writeback landing after an operand is captured does not update the captured value.
- Writebacks are processed in every state, including reset release and RSP stalls.

Decomposition:
- Package vx_gpr_pkg holds:
  - state enum (IDLE, READ, DRAIN, RSP)
  - RF_ADDRW = log2(NUM_WARPS*NUM_REGS)
  - function rf_addr(wid, reg)
  - operand-select enum (RS1, RS2, RS3)
- Sub-module vx_gpr_bank: 1R1W synchronous RAM with per-lane write mask and write-first same-address bypass. It holds no reset on storage.
- The collector FSM, operand registers and read-list sequencer stay in vx_gpr_collector.

Test Plan:
- Basic: preload w1 x5=0x11111111 and x6=0x22222222 in all lanes; request w1 rs1=5 rs2=6 use_rs3=0 -> rsp_valid 3 cycles after accept, rs1 lanes=0x11111111, rs2=0x22222222, rs3=0, rsp_wid=1.
- Zero and empty list:
  - wb to x0 with data 0xFFFFFFFF; request rs1=rs2=0, use_rs3=0 -> rsp_valid 1 cycle after accept, all data 0.
  - req_use_rs3=1, rs3=7 (x7=0x7) -> rs3 lanes=0x7, latency 2.
- Same-cycle bypass: x9=0xAAAA0000; wb x9 data 0x0000BBBB, tmask=0b0101, timed on rs1's read cycle -> rs1 lanes 0,2=0x0000BBBB and lanes 1,3=0xAAAA0000.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0; then rsp_ready=1 -> handshake, next cycle req_ready=1 and rsp_valid=0.
- Reset mid-READ: drop reset_n asynchronously during the second read -> outputs zero immediately; after release, state is IDLE, no spurious rsp_valid, and the bank keeps its previously written values.
- Warp isolation: write w0 x3=0x1 and w3 x3=0x3; request w3 rs1=3 -> 0x3 in all lanes.
